// File: rtl/draw_labels_if.sv
// -----------------------------------------------------------------------------
// draw_labels_if
// Groups the VGA stream, the font-ROM glyph row and the selection inputs of
// draw_labels into one bundle.
//   master : stream producer / consumer (drives *_in, char_pixels, sel_*)
//   slave  : the overlay stage (drives *_out)
// Signals:
//   hcount_in, vcount_in [10:0]       stage-0 pixel position
//   hsync_in, vsync_in, hblnk_in, vblnk_in
//   rgb_in [11:0]                     stage-0 background colour
//   char_pixels [7:0]                 font-ROM row, aligned to stage 1
//   sel_col, sel_row [2:0], sel_valid selected square
//   hcount_out ... rgb_out            stream two clocks later
// -----------------------------------------------------------------------------
interface draw_labels_if;
   logic [10:0] hcount_in;
   logic [10:0] vcount_in;
   logic        hsync_in;
   logic        vsync_in;
   logic        hblnk_in;
   logic        vblnk_in;
   logic [11:0] rgb_in;
   logic [7:0]  char_pixels;
   logic [2:0]  sel_col;
   logic [2:0]  sel_row;
   logic        sel_valid;
   logic [10:0] hcount_out;
   logic [10:0] vcount_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        hblnk_out;
   logic        vblnk_out;
   logic [11:0] rgb_out;

   modport master (
      output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
             char_pixels, sel_col, sel_row, sel_valid,
      input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
   );

   modport slave (
      input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
             char_pixels, sel_col, sel_row, sel_valid,
      output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
   );
endinterface

// File: rtl/draw_labels.sv
// -----------------------------------------------------------------------------
// draw_labels
// Two-stage pixel overlay painting the file (A-H) and rank (1-8) labels around
// the 512x512 board. Labels of the latched selected square blink in HL_COLOR.
// Ports:
//   i_clk    pixel clock
//   i_rst_n  synchronous active-low reset
//   io_vga   draw_labels_if.slave (VGA stream in/out, glyph row, selection)
// Build option:
//   LABELS_BOX_EN  when defined, non-glyph pixels inside the label strips are
//                  filled with BOX_COLOR (outside blanking).
// -----------------------------------------------------------------------------
module draw_labels #(
   parameter logic [11:0] LABEL_COLOR  = 12'h000,
   parameter logic [11:0] HL_COLOR     = 12'hF00,
   parameter logic [11:0] BOX_COLOR    = 12'hEEE,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   draw_labels_if.slave  io_vga
);

`ifdef LABELS_BOX_EN
   localparam bit BoxEn = 1'b1;
`else
   localparam bit BoxEn = 1'b0;
`endif

   localparam logic [7:0] CntLast = 8'(BLINK_FRAMES - 1);

   typedef enum logic {StOn, StOff} blink_state_e;

   // ---------------- stage-0 decode ----------------
   logic [10:0] w_h, w_v;
   logic        w_file_strip, w_rank_strip, w_in_strip, w_in_glyph;
   logic        w_file_span, w_rank_span, w_idx_match, w_is_hl, w_frame_start;
   logic [2:0]  w_col;
   logic [4:0]  w_file_idx, w_rank_idx;

   // selection latch and blink state
   logic [2:0]   r_sel_c, r_sel_r, w_sel_c_next, w_sel_r_next;
   logic         r_sel_active, w_sel_active_next;
   logic [7:0]   r_frame_cnt, w_frame_cnt_next;
   blink_state_e r_blink, w_blink_next;

   assign w_h = io_vga.hcount_in;
   assign w_v = io_vga.vcount_in;

   assign w_file_strip = (w_h >= 11'd256) && (w_h <= 11'd768) &&
                         (((w_v >= 11'd104) && (w_v <= 11'd120)) ||
                          ((w_v >= 11'd648) && (w_v <= 11'd664)));
   assign w_rank_strip = (w_v >= 11'd128) && (w_v <= 11'd640) &&
                         (((w_h >= 11'd236) && (w_h <= 11'd244)) ||
                          ((w_h >= 11'd780) && (w_h <= 11'd788)));
   assign w_file_span  = (w_h[5:0] >= 6'd28) && (w_h[5:0] <= 6'd35);
   assign w_rank_span  = (w_v[5:0] >= 6'd24) && (w_v[5:0] <= 6'd40);
   assign w_in_strip   = w_file_strip | w_rank_strip;
   assign w_in_glyph   = (w_file_strip & w_file_span) | (w_rank_strip & w_rank_span);

   // Glyph cells start 4 pixels before a multiple of 8.
   assign w_col      = w_h[2:0] + 3'd4;
   // Indices wrap outside 0..7 at the strip ends, so they never match a selection.
   assign w_file_idx = w_h[10:6] - 5'd4;
   assign w_rank_idx = 5'd9 - w_v[10:6];

   assign w_idx_match = w_file_strip ? (w_file_idx == {2'b00, r_sel_c})
                                     : (w_rank_idx == {2'b00, r_sel_r});
   assign w_is_hl       = r_sel_active & (r_blink == StOn) & w_idx_match;
   assign w_frame_start = (w_h == 11'd0) && (w_v == 11'd0);

   // ---------------- selection latch / blink FSM ----------------
   always_comb begin
      w_sel_c_next      = r_sel_c;
      w_sel_r_next      = r_sel_r;
      w_sel_active_next = r_sel_active;
      w_frame_cnt_next  = r_frame_cnt;
      w_blink_next      = r_blink;
      if (w_frame_start) begin
         w_sel_c_next      = io_vga.sel_col;
         w_sel_r_next      = io_vga.sel_row;
         w_sel_active_next = io_vga.sel_valid;
         if (!io_vga.sel_valid) begin
            w_frame_cnt_next = 8'd0;
            w_blink_next     = StOn;
         end else if (r_sel_active) begin
            // The activating frame is frame 0 of the first ON half-period,
            // so counting starts from the following frame start.
            if (r_frame_cnt == CntLast) begin
               w_frame_cnt_next = 8'd0;
               w_blink_next     = (r_blink == StOn) ? StOff : StOn;
            end else begin
               w_frame_cnt_next = r_frame_cnt + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sel_c      <= 3'd0;
         r_sel_r      <= 3'd0;
         r_sel_active <= 1'b0;
         r_frame_cnt  <= 8'd0;
         r_blink      <= StOn;
      end else begin
         r_sel_c      <= w_sel_c_next;
         r_sel_r      <= w_sel_r_next;
         r_sel_active <= w_sel_active_next;
         r_frame_cnt  <= w_frame_cnt_next;
         r_blink      <= w_blink_next;
      end
   end

   // ---------------- stage 1 ----------------
   logic [10:0] r1_hcount, r1_vcount;
   logic        r1_hsync, r1_vsync, r1_hblnk, r1_vblnk;
   logic [11:0] r1_rgb;
   logic        r1_in_glyph, r1_in_strip, r1_is_hl;
   logic [2:0]  r1_col;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r1_hcount   <= 11'd0;
         r1_vcount   <= 11'd0;
         r1_hsync    <= 1'b0;
         r1_vsync    <= 1'b0;
         r1_hblnk    <= 1'b0;
         r1_vblnk    <= 1'b0;
         r1_rgb      <= 12'd0;
         r1_in_glyph <= 1'b0;
         r1_in_strip <= 1'b0;
         r1_is_hl    <= 1'b0;
         r1_col      <= 3'd0;
      end else begin
         r1_hcount   <= w_h;
         r1_vcount   <= w_v;
         r1_hsync    <= io_vga.hsync_in;
         r1_vsync    <= io_vga.vsync_in;
         r1_hblnk    <= io_vga.hblnk_in;
         r1_vblnk    <= io_vga.vblnk_in;
         r1_rgb      <= io_vga.rgb_in;
         r1_in_glyph <= w_in_glyph;
         r1_in_strip <= w_in_strip;
         r1_is_hl    <= w_is_hl;
         r1_col      <= w_col;
      end
   end

   // ---------------- stage 2 ----------------
   logic        w_pix;
   logic [11:0] w_rgb_next;

   // char_pixels belongs to the stage-1 position; bit 7 is leftmost.
   assign w_pix = io_vga.char_pixels[3'd7 - r1_col];

   always_comb begin
      w_rgb_next = r1_rgb;
      if (r1_hblnk | r1_vblnk) begin
         w_rgb_next = r1_rgb;
      end else if (r1_in_glyph & w_pix) begin
         w_rgb_next = r1_is_hl ? HL_COLOR : LABEL_COLOR;
      end else if (BoxEn && r1_in_strip) begin
         w_rgb_next = BOX_COLOR;
      end
   end

   logic [10:0] r2_hcount, r2_vcount;
   logic        r2_hsync, r2_vsync, r2_hblnk, r2_vblnk;
   logic [11:0] r2_rgb;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r2_hcount <= 11'd0;
         r2_vcount <= 11'd0;
         r2_hsync  <= 1'b0;
         r2_vsync  <= 1'b0;
         r2_hblnk  <= 1'b0;
         r2_vblnk  <= 1'b0;
         r2_rgb    <= 12'd0;
      end else begin
         r2_hcount <= r1_hcount;
         r2_vcount <= r1_vcount;
         r2_hsync  <= r1_hsync;
         r2_vsync  <= r1_vsync;
         r2_hblnk  <= r1_hblnk;
         r2_vblnk  <= r1_vblnk;
         r2_rgb    <= w_rgb_next;
      end
   end

   assign io_vga.hcount_out = r2_hcount;
   assign io_vga.vcount_out = r2_vcount;
   assign io_vga.hsync_out  = r2_hsync;
   assign io_vga.vsync_out  = r2_vsync;
   assign io_vga.hblnk_out  = r2_hblnk;
   assign io_vga.vblnk_out  = r2_vblnk;
   assign io_vga.rgb_out    = r2_rgb;

endmodule

// File: tb/tb_draw_labels.sv
// -----------------------------------------------------------------------------
// tb_draw_labels
// Randomised stream through draw_labels, checked against a reference model
// built from the label geometry and blink rules with plain integer arithmetic.
// A "frame" here is simply the span between two (0,0) pixels.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_draw_labels;
   localparam int unsigned BF      = 2;
   localparam logic [11:0] LABEL_C = 12'h000;
   localparam logic [11:0] HL_C    = 12'hF00;
   localparam logic [11:0] BOX_C   = 12'hEEE;
   localparam logic [11:0] BG      = 12'h5A5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   draw_labels_if vga ();

   draw_labels #(
      .LABEL_COLOR  (LABEL_C),
      .HL_COLOR     (HL_C),
      .BOX_COLOR    (BOX_C),
      .BLINK_FRAMES (BF)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_vga  (vga)
   );

   typedef struct {
      logic [25:0] timing;
      logic [11:0] rgb;
      bit          has_want;
      logic [11:0] want;
      string       tag;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  prev_char = 8'h00;

   // model state: latched selection and frames since activation
   int m_sel_c = 0, m_sel_r = 0, m_k = 0;
   bit m_active = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] model_rgb(input int h, input int v, input bit hb, input bit vb,
                                             input logic [11:0] rgb, input logic [7:0] chr);
      bit file, rank, glyph, pix, hl, on;
      int lbl, sel;
      file  = h >= 256 && h <= 768 && ((v >= 104 && v <= 120) || (v >= 648 && v <= 664));
      rank  = v >= 128 && v <= 640 && ((h >= 236 && h <= 244) || (h >= 780 && h <= 788));
      glyph = (file && h % 64 >= 28 && h % 64 <= 35) || (rank && v % 64 >= 24 && v % 64 <= 40);
      pix   = chr[7 - ((h + 4) % 8)];
      lbl   = file ? h / 64 - 4 : 9 - v / 64;
      sel   = file ? m_sel_c : m_sel_r;
      on    = ((m_k / int'(BF)) % 2) == 0;
      hl    = m_active && on && (lbl == sel);
      if (hb || vb) return rgb;
      if (glyph && pix) return hl ? HL_C : LABEL_C;
`ifdef LABELS_BOX_EN
      if (file || rank) return BOX_C;
`endif
      return rgb;
   endfunction

   // Drives one stage-0 pixel; the glyph row for it is driven on the next call.
   task automatic px(input int h, input int v, input bit hs, input bit vs, input bit hb,
                     input bit vb, input logic [11:0] rgb, input logic [7:0] chr,
                     input bit has_want, input logic [11:0] want, input string tag);
      exp_t e, o;
      vga.hcount_in   = 11'(h);
      vga.vcount_in   = 11'(v);
      vga.hsync_in    = hs;
      vga.vsync_in    = vs;
      vga.hblnk_in    = hb;
      vga.vblnk_in    = vb;
      vga.rgb_in      = rgb;
      vga.char_pixels = prev_char;
      prev_char       = chr;
      e.timing   = {11'(h), 11'(v), hs, vs, hb, vb};
      e.rgb      = model_rgb(h, v, hb, vb, rgb, chr);
      e.has_want = has_want;
      e.want     = want;
      e.tag      = tag;
      q.push_back(e);
      if (h == 0 && v == 0) begin
         if (vga.sel_valid) begin
            m_k      = m_active ? m_k + 1 : 0;
            m_active = 1'b1;
            m_sel_c  = int'(vga.sel_col);
            m_sel_r  = int'(vga.sel_row);
         end else begin
            m_active = 1'b0;
            m_k      = 0;
         end
      end
      @(posedge clk);
      #1;
      if (q.size() == 2) begin
         o = q.pop_front();
         check("rgb", 64'(vga.rgb_out), 64'(o.rgb));
         check("timing", 64'({vga.hcount_out, vga.vcount_out, vga.hsync_out, vga.vsync_out,
                              vga.hblnk_out, vga.vblnk_out}), 64'(o.timing));
         if (o.has_want) check(o.tag, 64'(vga.rgb_out), 64'(o.want));
      end
   endtask

   task automatic dpx(input int h, input int v, input logic [7:0] chr, input logic [11:0] want,
                      input string tag);
      px(h, v, 1'b0, 1'b0, 1'b0, 1'b0, BG, chr, 1'b1, want, tag);
   endtask

   task automatic frame_start();
      px(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, BG, 8'h00, 1'b0, 12'h000, "");
   endtask

   task automatic rand_px();
      int h, v;
      logic [7:0] chr;
      case ($urandom_range(0, 3))
         0: begin
            h = 64 * int'($urandom_range(4, 12)) + int'($urandom_range(24, 39));
            v = ($urandom_range(0, 1) != 0 ? 646 : 102) + int'($urandom_range(0, 20));
         end
         1: begin
            v = 64 * int'($urandom_range(2, 10)) + int'($urandom_range(20, 44));
            h = ($urandom_range(0, 1) != 0 ? 779 : 235) + int'($urandom_range(0, 10));
         end
         2: begin
            h = int'($urandom_range(250, 262));
            v = int'($urandom_range(100, 130));
         end
         default: begin
            h = int'($urandom_range(1, 1023));
            v = int'($urandom_range(1, 767));
         end
      endcase
      case ($urandom_range(0, 3))
         0:       chr = 8'h00;
         1:       chr = 8'hFF;
         default: chr = 8'($urandom);
      endcase
      px(h, v, 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
         12'($urandom), chr, 1'b0, 12'h000, "");
   endtask

   task automatic do_reset(input int n);
      exp_t z;
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         vga.hcount_in   = 11'($urandom_range(0, 1023));
         vga.vcount_in   = 11'($urandom_range(0, 767));
         vga.hsync_in    = 1'b1;
         vga.vsync_in    = 1'b1;
         vga.hblnk_in    = 1'($urandom);
         vga.vblnk_in    = 1'($urandom);
         vga.rgb_in      = 12'($urandom);
         vga.char_pixels = 8'hFF;
         @(posedge clk);
         #1;
         check("rst_rgb", 64'(vga.rgb_out), 64'd0);
         check("rst_timing", 64'({vga.hcount_out, vga.vcount_out, vga.hsync_out, vga.vsync_out,
                                  vga.hblnk_out, vga.vblnk_out}), 64'd0);
      end
      m_active = 1'b0;
      m_k      = 0;
      m_sel_c  = 0;
      m_sel_r  = 0;
      q.delete();
      // The first output after release comes from the cleared stage 1.
      z.timing   = 26'd0;
      z.rgb      = 12'd0;
      z.has_want = 1'b0;
      z.want     = 12'd0;
      z.tag      = "";
      q.push_back(z);
      rst_n = 1'b1;
   endtask

   logic [11:0] plain_want;

   initial begin
`ifdef LABELS_BOX_EN
      plain_want = BOX_C;
`else
      plain_want = BG;
`endif
      vga.sel_col   = 3'd0;
      vga.sel_row   = 3'd0;
      vga.sel_valid = 1'b0;
      do_reset(5);

      // F0: select C / rank 6
      vga.sel_col = 3'd2; vga.sel_row = 3'd5; vga.sel_valid = 1'b1;
      frame_start();
      dpx(284, 110, 8'h80, LABEL_C, "a_glyph");
      dpx(284, 110, 8'h00, plain_want, "a_noglyph");
      dpx(416, 112, 8'h08, HL_C, "c_hl_f0");
      dpx(480, 112, 8'h08, LABEL_C, "d_plain_f0");
      px(416, 112, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123, 8'h08, 1'b1, 12'h123, "hblank");
      vga.sel_col = 3'd3;
      dpx(100, 300, 8'hFF, BG, "midframe");
      dpx(416, 112, 8'h08, HL_C, "c_hl_after_change");
      // F1: D selected, still ON
      frame_start();
      dpx(480, 112, 8'h08, HL_C, "d_hl_f1");
      dpx(416, 112, 8'h08, LABEL_C, "c_plain_f1");
      // F2, F3: OFF
      frame_start();
      dpx(480, 112, 8'h08, LABEL_C, "d_off_f2");
      frame_start();
      dpx(480, 656, 8'h08, LABEL_C, "d_off_f3");
      // F4: ON again
      frame_start();
      dpx(480, 656, 8'h08, HL_C, "d_on_f4");
      // F5: selection dropped
      vga.sel_valid = 1'b0;
      frame_start();
      dpx(480, 112, 8'h08, LABEL_C, "d_dropped");
      // F6: reselected, counter restarted so ON
      vga.sel_valid = 1'b1;
      frame_start();
      dpx(480, 112, 8'h08, HL_C, "d_reselect");
      dpx(240, 288, 8'h08, HL_C, "rank6_left");
      dpx(784, 288, 8'h08, HL_C, "rank6_right");
      dpx(784, 352, 8'h08, LABEL_C, "rank5_right");

      for (int f = 0; f < 120; f++) begin
         int chg;
         frame_start();
         chg = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 49)) : -1;
         for (int p = 0; p < 50; p++) begin
            if (p == chg) begin
               vga.sel_col   = 3'($urandom);
               vga.sel_row   = 3'($urandom);
               vga.sel_valid = $urandom_range(0, 3) != 0;
            end
            if (f == 60 && p == 25) do_reset(3);
            rand_px();
         end
      end
      px(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, BG, 8'h00, 1'b0, 12'h000, "");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
